// File: rtl/sm_addsub_serial_pkg.sv
// Shared constants and types for the serial
// sign-magnitude add/subtract unit.
package sm_pkg;

  localparam int W_DEF = 4;

  // Counter width for a W-step serial loop
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(W_DEF);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    EXEC,
    DONE
  } state_t;

endpackage

// File: rtl/sm_addsub_serial_full_adder.sv
// 1-bit full adder cell, reused by the serial
// datapath once per EXEC cycle.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Plain sum and majority carry
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/sm_addsub_serial.sv
// Bit-serial sign-magnitude adder/subtractor.
// Larger magnitude goes to X, one bit per cycle.
module sm_addsub_serial
  import sm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         a_sign,
  input  logic [W-1:0] a_mag,
  input  logic         b_sign,
  input  logic [W-1:0] b_mag,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         res_sign,
  output logic [W-1:0] res_mag,
  output logic         overflow
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_eff_sub;
  logic          r_a_sign;
  logic          r_b_sign;
  logic [W-1:0]  r_a_mag;
  logic [W-1:0]  r_b_mag;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic          r_sign;
  logic [W-1:0]  r_res_mag;
  logic          r_ovf;

  logic          w_accept;
  logic          w_a_sign;
  logic          w_b_sign;
  logic          w_swap;
  logic          w_last;
  logic          w_yb;
  logic          w_s;
  logic          w_c;
  logic [W-1:0]  w_shift;

  // Negative zero folds to +0 before the op flip
  always_comb begin
    w_a_sign = a_sign & (|a_mag);
    w_b_sign = (b_sign & (|b_mag)) ^ op;
    w_accept = in_valid & in_ready;
    w_swap   = r_eff_sub & (r_b_mag > r_a_mag);
    w_last   = (r_cnt == LAST);
    w_yb     = r_eff_sub ? ~r_y[0] : r_y[0];
    w_shift  = {w_s, r_res_mag[W-1:1]};
  end

  full_adder u_fa (
    .a    (r_x[0]),
    .b    (w_yb),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ALIGN;
      end
      ALIGN: w_next = EXEC;
      EXEC: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, swap and serial datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_eff_sub <= 1'b0;
      r_a_sign  <= 1'b0;
      r_b_sign  <= 1'b0;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_sign    <= 1'b0;
      r_res_mag <= '0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sign  <= w_a_sign;
            r_b_sign  <= w_b_sign;
            r_a_mag   <= a_mag;
            r_b_mag   <= b_mag;
            r_eff_sub <= w_a_sign ^ w_b_sign;
          end
        end
        ALIGN: begin
          r_x     <= w_swap ? r_b_mag : r_a_mag;
          r_y     <= w_swap ? r_a_mag : r_b_mag;
          r_sign  <= w_swap ? r_b_sign : r_a_sign;
          r_carry <= r_eff_sub;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end
        EXEC: begin
          r_res_mag <= w_shift;
          r_x       <= r_x >> 1;
          r_y       <= r_y >> 1;
          r_carry   <= w_c;
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt <= '0;
            r_ovf <= ~r_eff_sub & w_c;
            if (w_shift == '0) r_sign <= 1'b0;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    res_sign = r_sign;
    res_mag  = r_res_mag;
    overflow = r_ovf;
  end

endmodule

// File: doc/sm_addsub_serial.md
# sm_addsub_serial

Bit-serial sign-magnitude adder/subtractor that accepts two 4-bit sign-magnitude operands and returns a sign-magnitude result.
- It rebuilds the signed answer that the magnitude-only subtractor path drops:
  - picks the larger magnitude;
  - subtracts or adds one bit per cycle;
  - assigns the result sign explicitly.
- It sits between operand sources and the display/result registers.
- It replaces the combinational negate-then-correct path with a small, fixed-latency sequential unit that uses a valid/ready handshake.

## Interface
- W, 4, magnitude width in bits. All datapath widths and the serial step count derive from W.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  unit can accept operands. High only in IDLE.
- a_sign  in  1  sign of A (1 = negative).
- a_mag  in  W  magnitude of A.
- b_sign  in  1  sign of B.
- b_mag  in  W  magnitude of B.
- op  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- res_sign  out  1  result sign.
- res_mag  out  W  result magnitude.
- overflow  out  1  magnitude carry-out on the add path.

## Operation
- Accept on the rising edge where in_valid && in_ready. Register a_sign, a_mag, b_sign ^ op (effective B sign), and b_mag.
- eff_sub = a_sign ^ b_sign ^ op.
- Negative zero on input (sign 1, mag 0) is treated as +0.
- FSM states: IDLE → ALIGN → EXEC → DONE → IDLE.
- IDLE: in_ready = 1. Accept → ALIGN.
- ALIGN (1 cycle): compare magnitudes.
  - If eff_sub and b_mag > a_mag, swap the operands so X = larger and Y = smaller.
  - Result sign = sign of X.
  - When not subtracting, X = A, Y = B, and the sign is a_sign.
- EXEC (W cycles, bit counter 0..W−1): one full_adder step per cycle on X[i] and (eff_sub ? ~Y[i] : Y[i]).
  - Carry register init = eff_sub (two's-complement +1).
  - The sum bit shifts into res_mag from the MSB side, so after W steps res_mag is LSB-aligned.
- DONE: out_valid = 1. Hold res_sign, res_mag and overflow stable until out_valid && out_ready, then go to IDLE.
- Overflow:
  - Add path: overflow = final carry; res_mag = low W bits.
  - Subtract path: overflow = 0, and the final carry is discarded (it is always 1 because X ≥ Y).
- Zero result: if res_mag == 0, res_sign is forced to 0 when entering DONE.
- in_valid is ignored outside IDLE. No queueing, one operation in flight.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, res_sign 0, res_mag 0, overflow 0, counter 0, carry 0.
- Latency: accept at edge 0 → ALIGN in cycle 1 → EXEC cycles 2..W+1 → out_valid high from cycle W+2 (cycle 6 for W = 4).
- Throughput: one result per W+3 cycles with out_ready tied high, because IDLE costs one cycle after the handshake.
- in_ready falls the cycle after accept and rises the cycle after the output handshake.
- out_ready low: DONE persists indefinitely, outputs frozen, in_ready stays 0.
- out_ready high before DONE: no effect.
- rst asserted in any state:
  - immediate return to reset values;
  - the in-flight operation is dropped and no out_valid pulse occurs;
  - the first accept is possible on the first edge after rst deasserts.
- Operand inputs need be valid only at the accept edge.

## Structure
- Package sm_pkg holds:
  - the W default constant;
  - the state enum (IDLE, ALIGN, EXEC, DONE);
  - the counter width, $clog2(W).
- Sub-module full_adder (a, b, cin → s, cout) is instantiated once and reused every EXEC cycle. This is the codebase's existing 1-bit adder cell.
- Everything else (FSM, swap mux, shift register, zero check) lives in the top.

## Test plan
- (+5) + (+3), op = 0 → res_sign 0, res_mag 8, overflow 0. out_valid first high 6 cycles after accept.
- (+3) − (+5), op = 1 → res_sign 1, res_mag 2, overflow 0. Checks the swap and the sign of the larger operand.
- (−9) + (−9) → res_sign 1, res_mag 2, overflow 1.
- (+7) − (+7) and (−0) + (+0) → res_sign 0, res_mag 0, overflow 0. Checks negative-zero suppression.
- Backpressure: (−6) + (+2) with out_ready low for 3 cycles in DONE → res_sign 1, res_mag 4 held constant, in_ready 0 throughout. A second in_valid during the stall is not accepted.
- rst pulsed during EXEC bit 2 → all outputs go to reset values asynchronously and no out_valid appears. A new (+1) + (+1) → res_mag 2 with normal 6-cycle latency.
